// File: rtl/stream_element_counter.sv
// stream_element_counter
//   Pass-through stage for an ndata stream (NUM_ELEMENTS lanes with per-lane
//   keep and last). Counts kept elements and accepted beats of each stream and
//   publishes one {elems, beats} record per stream on a ready/valid channel
//   once the stream's last beat is accepted.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     in_data/in_keep/in_last/in_valid/in_ready      upstream beat channel
//     out_data/out_keep/out_last/out_valid/out_ready downstream beat channel
//     count_elems/count_beats/count_valid/count_ready per-stream record channel
//     count_overflow    (only with STREAM_ELEMENT_COUNTER_SATURATE_EN) record
//                       flag: a counter saturated somewhere in the stream
//
//   Build option: define STREAM_ELEMENT_COUNTER_SATURATE_EN to make both
//   counters saturate at 2^COUNT_WIDTH-1 and add count_overflow. Without it
//   the counters wrap modulo 2^COUNT_WIDTH.
module stream_element_counter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_ELEMENTS-1:0]            in_keep,
    input  logic                               in_last,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [NUM_ELEMENTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_ELEMENTS-1:0]            out_keep,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COUNT_WIDTH-1:0]             count_elems,
    output logic [COUNT_WIDTH-1:0]             count_beats,
    output logic                               count_valid,
    input  logic                               count_ready
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
    ,
    output logic                               count_overflow
`endif
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [NUM_ELEMENTS-1:0] k);
        logic [COUNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            c = c + COUNT_WIDTH'(k[i]);
        end
        return c;
    endfunction

`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
    function automatic logic cnt_carry(input logic [COUNT_WIDTH-1:0] a,
                                       input logic [COUNT_WIDTH-1:0] b);
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COUNT_WIDTH];
    endfunction

    // Clamp to all-ones when the true sum does not fit.
    function automatic logic [COUNT_WIDTH-1:0] cnt_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [COUNT_WIDTH-1:0] b);
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
    endfunction
`else
    function automatic logic [COUNT_WIDTH-1:0] cnt_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [COUNT_WIDTH-1:0] b);
        return a + b;
    endfunction
`endif

    logic [COUNT_WIDTH-1:0] acc_elems;
    logic [COUNT_WIDTH-1:0] acc_beats;
    logic [COUNT_WIDTH-1:0] keep_cnt;
    logic [COUNT_WIDTH-1:0] sum_elems;
    logic [COUNT_WIDTH-1:0] sum_beats;
    logic                   stall;
    logic                   fire;

    // Only a last beat needs the record slot, so only it waits on a pending
    // record; non-last beats of the following stream keep flowing.
    assign stall     = in_last && count_valid && !count_ready;
    assign in_ready  = out_ready && !stall && !rst;
    assign out_valid = in_valid && !stall && !rst;
    assign fire      = in_valid && in_ready;

    assign out_data  = in_data;
    assign out_keep  = in_keep;
    assign out_last  = in_last;

    assign keep_cnt  = popcount(in_keep);
    assign sum_elems = cnt_add(acc_elems, keep_cnt);
    assign sum_beats = cnt_add(acc_beats, ONE);

`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
    logic acc_ovf;
    logic step_ovf;
    assign step_ovf = cnt_carry(acc_elems, keep_cnt) | cnt_carry(acc_beats, ONE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_elems   <= '0;
            acc_beats   <= '0;
            count_elems <= '0;
            count_beats <= '0;
            count_valid <= 1'b0;
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
            acc_ovf        <= 1'b0;
            count_overflow <= 1'b0;
`endif
        end else begin
            if (fire) begin
                if (in_last) begin
                    count_elems <= sum_elems;
                    count_beats <= sum_beats;
                    count_valid <= 1'b1;
                    acc_elems   <= '0;
                    acc_beats   <= '0;
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
                    count_overflow <= acc_ovf | step_ovf;
                    acc_ovf        <= 1'b0;
`endif
                end else begin
                    acc_elems <= sum_elems;
                    acc_beats <= sum_beats;
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
                    acc_ovf   <= acc_ovf | step_ovf;
`endif
                end
            end
            // A record loaded in the same cycle as a consume keeps valid high.
            if (count_valid && count_ready && !(fire && in_last)) begin
                count_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_element_counter.sv
module tb_stream_element_counter;

    localparam int DW = 32;
    localparam int NE = 8;
    localparam int CW = 32;

    logic             clk;
    logic             rst;
    logic [NE*DW-1:0] in_data;
    logic [NE-1:0]    in_keep;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [NE*DW-1:0] out_data;
    logic [NE-1:0]    out_keep;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count_elems;
    logic [CW-1:0]    count_beats;
    logic             count_valid;
    logic             count_ready;

    // Narrow-counter instance for the wrap / saturate case.
    logic [NE*DW-1:0] w_in_data;
    logic [NE-1:0]    w_in_keep;
    logic             w_in_last;
    logic             w_in_valid;
    logic             w_in_ready;
    logic [NE*DW-1:0] w_out_data;
    logic [NE-1:0]    w_out_keep;
    logic             w_out_last;
    logic             w_out_valid;
    logic             w_out_ready;
    logic [3:0]       w_count_elems;
    logic [3:0]       w_count_beats;
    logic             w_count_valid;
    logic             w_count_ready;
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
    logic             count_overflow;
    logic             w_count_overflow;
`endif

    stream_element_counter #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .count_elems(count_elems), .count_beats(count_beats),
        .count_valid(count_valid), .count_ready(count_ready)
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
        , .count_overflow(count_overflow)
`endif
    );

    stream_element_counter #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE), .COUNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_data(w_in_data), .in_keep(w_in_keep), .in_last(w_in_last),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_keep(w_out_keep), .out_last(w_out_last),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .count_elems(w_count_elems), .count_beats(w_count_beats),
        .count_valid(w_count_valid), .count_ready(w_count_ready)
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
        , .count_overflow(w_count_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned e;
        int unsigned b;
    } rec_t;

    rec_t        q[$];
    int unsigned acc_e;
    int unsigned acc_b;
    int          checks;
    int          errors;
    int          recs;
    bit          bp_en;

    // Reference model and scoreboard, evaluated mid-cycle when inputs and the
    // DUT's combinational outputs are settled.
    always @(negedge clk) begin
        logic exp_stall;
        rec_t r;
        if (rst) begin
            q.delete();
            acc_e = 0;
            acc_b = 0;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_gate in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
            end
        end else begin
            exp_stall = in_last && (q.size() != 0) && !count_ready;
            checks++;
            if (in_ready !== (out_ready && !exp_stall)) begin
                errors++;
                $display("FAIL in_ready got %b required %b", in_ready, out_ready && !exp_stall);
            end
            checks++;
            if (out_valid !== (in_valid && !exp_stall)) begin
                errors++;
                $display("FAIL out_valid got %b required %b", out_valid, in_valid && !exp_stall);
            end
            checks++;
            if (out_data !== in_data || out_keep !== in_keep || out_last !== in_last) begin
                errors++;
                $display("FAIL passthrough keep got %h required %h last got %b required %b",
                         out_keep, in_keep, out_last, in_last);
            end
            checks++;
            if (count_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL count_valid got %b required %b", count_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (count_elems !== q[0].e || count_beats !== q[0].b) begin
                    errors++;
                    $display("FAIL record got {%0d,%0d} required {%0d,%0d}",
                             count_elems, count_beats, q[0].e, q[0].b);
                end
                if (count_ready) begin
                    void'(q.pop_front());
                    recs++;
                end
            end
            if (in_valid && out_ready && !exp_stall) begin
                if (in_last) begin
                    r.e = acc_e + $countones(in_keep);
                    r.b = acc_b + 1;
                    q.push_back(r);
                    acc_e = 0;
                    acc_b = 0;
                end else begin
                    acc_e = acc_e + $countones(in_keep);
                    acc_b = acc_b + 1;
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded). Returns at
    // posedge+1 of the accepting edge with in_valid dropped.
    task automatic send(input logic [NE-1:0] keep, input logic last, output int waited);
        bit done;
        done     = 0;
        waited   = 0;
        in_valid = 1'b1;
        in_keep  = keep;
        in_last  = last;
        in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 200 && !done; n++) begin
            if (bp_en) begin
                out_ready   = 1'($urandom_range(0, 1));
                count_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (in_ready) done = 1;
            else waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout beat not accepted within 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b0 || count_elems !== '0 || count_beats !== '0) begin
            errors++;
            $display("FAIL reset_state valid=%b elems=%0d beats=%0d required 0 0 0",
                     count_valid, count_elems, count_beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int w;
        send(8'hFF, 1'b0, w);
        send(8'h0F, 1'b0, w);
        send(8'h81, 1'b1, w);
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b1 || count_elems !== 14 || count_beats !== 3) begin
            errors++;
            $display("FAIL basic_record valid=%b got {%0d,%0d} required 1 {14,3}",
                     count_valid, count_elems, count_beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty();
        int w;
        send(8'h00, 1'b1, w);
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b1 || count_elems !== 0 || count_beats !== 1) begin
            errors++;
            $display("FAIL empty_record valid=%b got {%0d,%0d} required 1 {0,1}",
                     count_valid, count_elems, count_beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int w;
        count_ready = 1'b0;
        send(8'hFF, 1'b1, w);
        for (int i = 0; i < 2; i++) begin
            send(8'hFF, 1'b0, w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL stall_nonlast waited %0d cycles required 0", w);
            end
        end
        in_valid = 1'b1;
        in_keep  = 8'h01;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_last in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
            end
            checks++;
            if (count_valid !== 1'b1 || count_elems !== 8 || count_beats !== 1) begin
                errors++;
                $display("FAIL stall_hold valid=%b got {%0d,%0d} required 1 {8,1}",
                         count_valid, count_elems, count_beats);
            end
            @(posedge clk);
            #1;
        end
        count_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b1 || count_elems !== 17 || count_beats !== 3) begin
            errors++;
            $display("FAIL stall_record_b valid=%b got {%0d,%0d} required 1 {17,3}",
                     count_valid, count_elems, count_beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        count_ready = 1'b1;
        in_valid    = 1'b1;
        in_keep     = 8'h03;
        in_last     = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_keep = 8'h07;
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b1 || count_elems !== 2 || count_beats !== 1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first valid=%b ready=%b got {%0d,%0d} required 1 1 {2,1}",
                     count_valid, in_ready, count_elems, count_beats);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b1 || count_elems !== 3 || count_beats !== 1) begin
            errors++;
            $display("FAIL b2b_second valid=%b got {%0d,%0d} required 1 {3,1}",
                     count_valid, count_elems, count_beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int w;
        int nb;
        int start;
        start = recs;
        bp_en = 1;
        for (int s = 0; s < 100; s++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                send(8'($urandom_range(0, 255)), 1'(b == nb - 1), w);
            end
        end
        bp_en       = 0;
        out_ready   = 1'b1;
        count_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (recs - start != 100 || q.size() != 0) begin
            errors++;
            $display("FAIL random_records consumed %0d required 100 left %0d", recs - start, q.size());
        end
    endtask

    task automatic test_reset_mid();
        int w;
        count_ready = 1'b0;
        send(8'h01, 1'b1, w);
        send(8'hFF, 1'b0, w);
        send(8'hFF, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b0 || count_elems !== 0) begin
            errors++;
            $display("FAIL midreset_state valid=%b elems=%0d required 0 0", count_valid, count_elems);
        end
        @(posedge clk);
        #1;
        count_ready = 1'b1;
        send(8'h0F, 1'b1, w);
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b1 || count_elems !== 4 || count_beats !== 1) begin
            errors++;
            $display("FAIL midreset_restart valid=%b got {%0d,%0d} required 1 {4,1}",
                     count_valid, count_elems, count_beats);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_width();
        logic [3:0] exp_e;
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
        exp_e = 4'd15;
`else
        exp_e = 4'd8;
`endif
        for (int i = 0; i < 3; i++) begin
            w_in_valid = 1'b1;
            w_in_keep  = 8'hFF;
            w_in_last  = 1'(i == 2);
            @(negedge clk);
            checks++;
            if (w_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL narrow_ready got %b required 1", w_in_ready);
            end
            @(posedge clk);
            #1;
        end
        w_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (w_count_valid !== 1'b1 || w_count_elems !== exp_e || w_count_beats !== 4'd3) begin
            errors++;
            $display("FAIL narrow_record valid=%b got {%0d,%0d} required 1 {%0d,3}",
                     w_count_valid, w_count_elems, w_count_beats, exp_e);
        end
`ifdef STREAM_ELEMENT_COUNTER_SATURATE_EN
        checks++;
        if (w_count_overflow !== 1'b1) begin
            errors++;
            $display("FAIL narrow_overflow got %b required 1", w_count_overflow);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        recs        = 0;
        bp_en       = 0;
        acc_e       = 0;
        acc_b       = 0;
        rst         = 1'b1;
        in_data     = '0;
        in_keep     = '0;
        in_last     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        count_ready = 1'b1;
        w_in_data   = '0;
        w_in_keep   = '0;
        w_in_last   = 1'b0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        w_count_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_count_width();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_element_counter.md
Name: stream_element_counter

Overview:
- Downstream stage of the data sink.
- Forwards an ndata stream (NUM_ELEMENTS lanes, per-lane keep, last) unchanged.
- Counts kept elements and accepted beats per stream, ending at each last beat, and emits one count record per stream on a separate ready/valid channel.
- Handles the disabled-stream case where a sink emits a single last beat with keep all-zero; that stream reports zero elements.

Parameters:
- DATA_WIDTH, 32, width of one element.
- NUM_ELEMENTS, 8, lanes per beat; must be ≥1.
- COUNT_WIDTH, 32, width of the element and beat counters; must be ≥ $clog2(NUM_ELEMENTS+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  NUM_ELEMENTS*DATA_WIDTH  input lanes.
- in_keep  in  NUM_ELEMENTS  per-lane valid mask; may be non-contiguous.
- in_last  in  1  final beat of the stream.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted.
- out_data  out  NUM_ELEMENTS*DATA_WIDTH  forwarded lanes.
- out_keep  out  NUM_ELEMENTS  forwarded keep.
- out_last  out  1  forwarded last.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- count_elems  out  COUNT_WIDTH  kept-element total of the completed stream.
- count_beats  out  COUNT_WIDTH  accepted-beat total of the completed stream, including the last beat.
- count_valid  out  1  count record valid.
- count_ready  in  1  count record consumed.

Behaviour:
- Data path is combinational, zero latency: out_data/out_keep/out_last = in_*.
- stall = in_last && count_valid && !count_ready.
- out_valid = in_valid && !stall && !rst.
- in_ready = out_ready && !stall && !rst.
- Beat accepted ("fire") when in_valid && in_ready.
- Registers: acc_elems, acc_beats (COUNT_WIDTH), count_elems, count_beats, count_valid.
- Reset: acc_* = 0, count_valid = 0, count_elems = count_beats = 0. in_ready = 0 and out_valid = 0 while rst is high.
- Reset mid-stream drops the partial accumulation; the next accepted beat starts a new stream.
- Fire with !in_last:
  - acc_elems += popcount(in_keep).
  - acc_beats += 1.
- Fire with in_last:
  - count_elems <= acc_elems + popcount(in_keep).
  - count_beats <= acc_beats + 1.
  - count_valid <= 1.
  - acc_* <= 0.
- Count handshake: count_valid && count_ready clears count_valid, unless a last beat fires in the same cycle. Simultaneous consume and load: the new record is loaded and count_valid stays 1, giving back-to-back records with no bubble.
- Record held: count_elems, count_beats and count_valid are stable while count_valid && !count_ready.
- Only last beats stall on a pending record. Non-last beats keep flowing, so the next stream's accumulation proceeds.
- Empty stream (a single last beat with keep = 0): record {elems = 0, beats = 1}.
- Arithmetic: popcount is zero-extended to COUNT_WIDTH. Overflow behaviour is set under Optional Feature.
- No internal FSM beyond count_valid; the states are IDLE (count_valid = 0) and PENDING (count_valid = 1).

Optional Feature:
- Macro: STREAM_ELEMENT_COUNTER_SATURATE_EN.
- Defined:
  - Both accumulators and the final sums saturate at 2^COUNT_WIDTH−1.
  - Extra port count_overflow (out, 1) is registered with the record: 1 if either counter saturated at any point in the stream.
  - count_overflow resets to 0.
- Undefined:
  - Counters wrap modulo 2^COUNT_WIDTH.
  - count_overflow port does not exist.

Test Plan:
- NUM_ELEMENTS = 8; three beats with keep 0xFF, 0x0F, 0x81 (last), all ready high → out mirrors in every cycle; one record {elems = 14, beats = 3}, count_valid asserted the cycle after the last beat fires.
- Single beat, keep = 0x00, last = 1 → forwarded unchanged; record {0, 1}.
- Hold count_ready = 0 after stream A ({8, 1}); stream B sends keep 0xFF, 0xFF, 0x01 (last):
  - The two non-last beats pass.
  - The last beat stalls (in_ready = 0, out_valid = 0) until count_ready pulses.
  - Record A is held stable, then B = {17, 3} follows.
- count_ready held 1; back-to-back single-beat streams with keep 0x03 then 0x07 on consecutive cycles → records {2, 1} and {3, 1} with count_valid continuously high, no bubble.
- Random out_ready backpressure over 100 streams → no beat dropped or duplicated; counts match the scoreboard. Assert rst mid-stream → count_valid = 0; the next stream counts from zero.
- COUNT_WIDTH = 4, macro defined; three beats of keep 0xFF → elems saturates at 15, count_overflow = 1. Macro undefined → elems = 8 (24 mod 16).
